clk_period_meter: RTL and testbench
===================================

Name: clk_period_meter

Overview:
Receive-side companion to the clock divider. It takes a divided or slow clock-like signal from elsewhere in the design or from a pin. It measures the signal's period and high time in cycles of the system clock. It reports each measurement with a one-cycle valid pulse, flags frequency lock after repeated identical periods, and flags a stalled input. It is used to check divider outputs in-system and to characterise external slow clocks.

Parameters:
WIDTH, 16, width of the period, high-time and internal counters
SYNC_STAGES, 2, number of synchroniser flops on sig_in (legal values ≥2)
TIMEOUT, 65535, clk cycles without a rising edge before stall is declared (legal range 2..2^WIDTH-1)
LOCK_COUNT, 4, consecutive identical periods required to assert locked (legal values ≥1)

Ports:
clk  input  1  system clock; all logic is on the rising edge
rst  input  1  asynchronous, active-low reset; rst=0 resets immediately, release is synchronous to clk
sig_in  input  1  asynchronous signal under measurement
period  output  WIDTH  last measured rising-to-rising interval, in clk cycles
high_time  output  WIDTH  last measured rising-to-falling interval, in clk cycles
meas_valid  output  1  one-cycle pulse when period/high_time are updated
locked  output  1  period has been stable for LOCK_COUNT measurements
stalled  output  1  no rising edge within TIMEOUT cycles

Behaviour:
- Reset values:
  - period=0, high_time=0, meas_valid=0, locked=0, stalled=0.
  - Synchroniser flops and previous-sample flop are 0.
  - cnt=0, hi_lat=0, match_cnt=0, last_period=0.
  - FSM is in IDLE.
- Synchronisation:
  - sig_in passes through SYNC_STAGES flops, giving s.
  - s_d is s delayed one clk.
  - rise = s & ~s_d; fall = ~s & s_d.
- Latency: meas_valid rises on the (SYNC_STAGES+1)th clk edge, counting the first edge that samples the new sig_in level.
- Period definition: if rise occurs in cycles t0 and t1, then period = t1 - t0 and high_time = tf - t0, where tf is the fall cycle between them.
- FSM states: IDLE, RUN.
  - IDLE: fall is ignored; cnt holds.
    - On rise: cnt<=1, go to RUN, stalled<=0, no meas_valid.
  - RUN, no edge: cnt<=cnt+1.
  - RUN, fall: hi_lat<=cnt; cnt<=cnt+1.
  - RUN, rise:
    - period<=cnt; high_time<=hi_lat; meas_valid<=1; cnt<=1.
    - Lock tracking: if cnt==last_period then match_cnt<=sat(match_cnt+1) else match_cnt<=1.
    - last_period<=cnt.
    - locked<=(new match_cnt ≥ LOCK_COUNT), registered in the same edge as meas_valid.
  - RUN, cnt==TIMEOUT and no rise this cycle:
    - stalled<=1, locked<=0, match_cnt<=0, last_period<=0, go to IDLE.
    - period and high_time hold their last values.
- Simultaneous rise and cnt==TIMEOUT: the rise wins. A normal measurement is taken with period=TIMEOUT; no stall.
- The first rise after reset or after a stall only arms the meter. The first meas_valid needs two rises.
- match_cnt saturates at LOCK_COUNT. locked deasserts on the first meas_valid whose period differs from the previous one, because match_cnt returns to 1. With LOCK_COUNT=1, locked asserts on every meas_valid.
- meas_valid is high for exactly one cycle per measured rise; it is never high in IDLE.
- Pulses on sig_in shorter than one clk may be missed; this is not an error condition.
- Reset mid-operation: all state returns to reset values at once. No meas_valid is produced for edges straddling the reset.

Test Plan:
1. Settling: rst=0 for 10 cycles, sig_in=0. Release reset, hold sig_in for 20 cycles → meas_valid never 1; period=0, locked=0, stalled=0.
2. Divide-by-10, 50% duty: sig_in toggles every 5 clk (LOCK_COUNT=4).
   - First meas_valid comes after the 2nd rise, with period=10, high_time=5.
   - locked=1 together with the 4th meas_valid and stays 1.
   - meas_valid is exactly 1 cycle wide, 10 cycles apart.
3. Duty and frequency change: after lock, switch sig_in to high 3 / low 9.
   - Next measurement is period=12, high_time=3.
   - locked drops on that meas_valid and reasserts on the 4th consecutive 12.
4. Stall with TIMEOUT=50: stop toggling after lock.
   - stalled=1 and locked=0 exactly 50 cycles after the last detected rise; period holds 12.
   - On resuming, the first rise clears stalled with no meas_valid; the next rise gives a valid measurement.
5. Boundary with TIMEOUT=50: period of exactly 50 → meas_valid with period=50, stalled stays 0. Period of 51 → stalled=1.
6. Reset mid-period: assert rst asynchronously between a rise and a fall.
   - All outputs are 0 immediately, without waiting for a clk edge.
   - After release, the first meas_valid requires two fresh rises.

Source files
------------

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow, asynchronous clock-like input in system clock cycles.
// It also reports frequency lock after repeated equal periods, and a stall when no rising edge arrives.
module clk_period_meter #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 65535,
    parameter int LOCK_COUNT  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             stalled,
    output logic             dbg_state
);

    localparam int MW = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [MW-1:0]    LOCK_MAX  = MW'(LOCK_COUNT);
    localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d_q;
    logic                   s, rise, fall;

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_lat_q, hi_lat_d;
    logic [WIDTH-1:0] last_period_q, last_period_d;
    logic [MW-1:0]    match_q, match_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             stalled_q, stalled_d;

    // Bit 0 takes the raw input; the oldest stage is the synchronised level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            s_d_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d_q;
    assign fall = ~s & s_d_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (rise) state_d = RUN;
            RUN:  if (!rise && cnt_q == TIMEOUT_W) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A rise coinciding with the timeout is a valid measurement, so rise is tested first.
    always_comb begin
        cnt_d         = cnt_q;
        hi_lat_d      = hi_lat_q;
        last_period_d = last_period_q;
        match_d       = match_q;
        period_d      = period_q;
        high_d        = high_q;
        valid_d       = 1'b0;
        locked_d      = locked_q;
        stalled_d     = stalled_q;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    cnt_d     = WIDTH'(1);
                    stalled_d = 1'b0;
                end
            end
            RUN: begin
                if (rise) begin
                    period_d = cnt_q;
                    high_d   = hi_lat_q;
                    valid_d  = 1'b1;
                    cnt_d    = WIDTH'(1);
                    if (cnt_q == last_period_q)
                        match_d = (match_q >= LOCK_MAX) ? LOCK_MAX : match_q + MW'(1);
                    else
                        match_d = MW'(1);
                    last_period_d = cnt_q;
                    locked_d      = (match_d >= LOCK_MAX);
                end else if (cnt_q == TIMEOUT_W) begin
                    stalled_d     = 1'b1;
                    locked_d      = 1'b0;
                    match_d       = '0;
                    last_period_d = '0;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                    if (fall) hi_lat_d = cnt_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q         <= '0;
            hi_lat_q      <= '0;
            last_period_q <= '0;
            match_q       <= '0;
            period_q      <= '0;
            high_q        <= '0;
            valid_q       <= 1'b0;
            locked_q      <= 1'b0;
            stalled_q     <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            hi_lat_q      <= hi_lat_d;
            last_period_q <= last_period_d;
            match_q       <= match_d;
            period_q      <= period_d;
            high_q        <= high_d;
            valid_q       <= valid_d;
            locked_q      <= locked_d;
            stalled_q     <= stalled_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_q;
    assign meas_valid = valid_q;
    assign locked     = locked_q;
    assign stalled    = stalled_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Bench for clk_period_meter: per-cycle comparison against an edge-timestamp model,
// a table of waveform vectors, and hand-written stall, boundary and reset sequences.
module tb_clk_period_meter;

    localparam int W    = 16;
    localparam int SYNC = 2;
    localparam int TO   = 50;
    localparam int LC   = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         sig_in;
    logic [W-1:0] period, high_time;
    logic         meas_valid, locked, stalled, dbg_state;

    int checks = 0;
    int errors = 0;

    clk_period_meter #(.WIDTH(W), .SYNC_STAGES(SYNC), .TIMEOUT(TO), .LOCK_COUNT(LC)) dut (
        .clk        (clk),
        .rst        (rst),
        .sig_in     (sig_in),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .locked     (locked),
        .stalled    (stalled),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [W-1:0] period;
        logic [W-1:0] high;
        logic         mv;
        logic         locked;
        logic         stalled;
    } obs_t;

    obs_t exp_q[$];
    obs_t m_out;
    int   cyc = 0;
    bit   m_prev, m_run;
    int   m_rise_edge, m_high_lat, m_last_p, m_match;

    // Monitor results used by the directed sequences.
    int n_meas = 0;
    int last_p = 0, last_h = 0, last_l = 0;
    int last_mv_edge = 0, stall_edge = 0;
    bit prev_stalled = 1'b0;

    task automatic model_reset();
        m_out = '0; m_prev = 0; m_run = 0;
        m_rise_edge = 0; m_high_lat = 0; m_last_p = 0; m_match = 0;
        exp_q.delete();
        for (int i = 0; i < SYNC; i++) exp_q.push_back(obs_t'(0));
    endtask

    // Timestamps of sampled rising/falling levels; outputs appear SYNC edges later.
    task automatic model_step(input bit smp);
        bit r, f;
        int p, el;
        r = smp & !m_prev;
        f = !smp & m_prev;
        m_prev = smp;
        m_out.mv = 1'b0;
        el = cyc - m_rise_edge;
        if (m_run) begin
            if (r) begin
                p = el;
                m_out.period = W'(p);
                m_out.high   = W'(m_high_lat);
                m_out.mv     = 1'b1;
                m_match      = (p == m_last_p) ? ((m_match + 1 > LC) ? LC : m_match + 1) : 1;
                m_last_p     = p;
                m_out.locked = (m_match >= LC);
                m_rise_edge  = cyc;
            end else if (el == TO) begin
                m_out.stalled = 1'b1;
                m_out.locked  = 1'b0;
                m_match = 0; m_last_p = 0; m_run = 0;
            end else if (f) begin
                m_high_lat = el;
            end
        end else if (r) begin
            m_run = 1; m_rise_edge = cyc; m_out.stalled = 1'b0;
        end
    endtask

    initial model_reset();

    always @(posedge clk) begin
        obs_t exp_o, act_o;
        cyc++;
        if (!rst) begin
            model_reset();
            exp_o = '0;
        end else begin
            model_step(sig_in);
            exp_q.push_back(m_out);
            exp_o = exp_q.pop_front();
        end
        #1;
        act_o = '{period, high_time, meas_valid, locked, stalled};
        checks++;
        if (act_o !== exp_o) begin
            errors++;
            $display("FAIL model cyc=%0d actual p=%0d h=%0d v=%0b l=%0b s=%0b expected p=%0d h=%0d v=%0b l=%0b s=%0b",
                     cyc, act_o.period, act_o.high, act_o.mv, act_o.locked, act_o.stalled,
                     exp_o.period, exp_o.high, exp_o.mv, exp_o.locked, exp_o.stalled);
        end
        if (meas_valid === 1'b1) begin
            n_meas++; last_p = period; last_h = high_time; last_l = locked; last_mv_edge = cyc;
        end
        if (stalled === 1'b1 && !prev_stalled) stall_edge = cyc;
        prev_stalled = (stalled === 1'b1);
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic drive_period(input int hi, input int lo);
        sig_in = 1'b1;
        repeat (hi) @(negedge clk);
        sig_in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic wait_stall(input int budget);
        int n;
        n = 0;
        while (stalled !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("stall_seen", int'(stalled === 1'b1), 1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int hi; int lo; int reps;
        int exp_n; int exp_period; int exp_high; int exp_locked;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{5, 5, 5, 4, 10, 5, 1};
        vecs[1] = '{3, 9, 4, 4, 12, 3, 0};
        vecs[2] = '{3, 9, 2, 2, 12, 3, 1};
        vecs[3] = '{7, 13, 3, 3, 20, 7, 0};
        vecs[4] = '{1, 4, 5, 5, 5, 1, 1};

        rst = 1'b0;
        sig_in = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_period", int'(period), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_state_idle", int'(dbg_state), 0);
        rst = 1'b1;
        n_meas = 0;
        repeat (20) @(negedge clk);
        check("settle_no_meas", n_meas, 0);
        check("settle_period", int'(period), 0);
        check("settle_locked", int'(locked), 0);
        check("settle_stalled", int'(stalled), 0);

        for (int v = 0; v < 5; v++) begin
            n_meas = 0;
            for (int r = 0; r < vecs[v].reps; r++) drive_period(vecs[v].hi, vecs[v].lo);
            check($sformatf("vec%0d_count", v), n_meas, vecs[v].exp_n);
            check($sformatf("vec%0d_period", v), last_p, vecs[v].exp_period);
            check($sformatf("vec%0d_high", v), last_h, vecs[v].exp_high);
            check($sformatf("vec%0d_locked", v), last_l, vecs[v].exp_locked);
        end

        // Stall after lock: exactly TIMEOUT cycles after the last measured rise.
        wait_stall(100);
        check("stall_delay", stall_edge - last_mv_edge, TO);
        check("stall_period_hold", int'(period), 5);
        check("stall_locked", int'(locked), 0);
        check("stall_state_idle", int'(dbg_state), 0);

        n_meas = 0;
        drive_period(5, 5);
        check("resume_stall_clear", int'(stalled), 0);
        check("resume_arm_no_meas", n_meas, 0);
        drive_period(5, 5);
        check("resume_meas_count", n_meas, 1);
        check("resume_period", last_p, 10);
        check("resume_high", last_h, 5);

        // Period of exactly TIMEOUT measures; one longer stalls.
        drive_period(10, 40);
        drive_period(10, 40);
        check("bound50_period", last_p, 50);
        check("bound50_no_stall", int'(stalled), 0);
        drive_period(10, 41);
        repeat (5) @(negedge clk);
        check("bound51_stalled", int'(stalled), 1);
        check("bound51_delay", stall_edge - last_mv_edge, TO);
        check("bound51_period_hold", int'(period), 50);

        // Lock again, then reset asynchronously inside a high phase.
        for (int i = 0; i < 8; i++) drive_period(4, 4);
        check("prereset_locked", int'(locked), 1);
        sig_in = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_period", int'(period), 0);
        check("async_high", int'(high_time), 0);
        check("async_locked", int'(locked), 0);
        check("async_valid", int'(meas_valid), 0);
        check("async_stalled", int'(stalled), 0);
        sig_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        n_meas = 0;
        drive_period(4, 4);
        check("postreset_arm", n_meas, 0);
        drive_period(4, 4);
        check("postreset_meas", n_meas, 1);
        check("postreset_period", last_p, 8);

        // Random waveforms, including gaps long enough to stall.
        for (int i = 0; i < 60; i++) drive_period($urandom_range(1, 25), $urandom_range(1, 60));
        repeat (60) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
